// File: rtl/aurora_ll_gen_pkg.sv
// aurora_ll_gen_pkg: payload modes, FSM encoding and PRBS helpers shared by the LocalLink generator
package aurora_ll_gen_pkg;
  typedef enum logic [1:0] {MODE_WALK = 2'b00, MODE_CNT = 2'b01, MODE_PRBS = 2'b10} mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_GAP} state_e;
  localparam logic [15:0] PRBS_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1, shifting toward bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction
  function automatic mode_e norm_mode(input logic [1:0] m);
    return m == 2'b11 ? MODE_WALK : mode_e'(m);
  endfunction
endpackage

// File: rtl/aurora_ll_pattern_src.sv
// aurora_ll_pattern_src: walking-one, counter and PRBS registers with a registered payload mux
module aurora_ll_pattern_src
  import aurora_ll_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  USER_CLK,
  input  logic                  RESET,
  input  logic                  adv,
  input  logic                  load,
  input  mode_e                 mode_sel,
  output logic [DATA_WIDTH-1:0] data
);
  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  logic [DATA_WIDTH-1:0] walk_q, walk_n, cnt_q, cnt_n;
  logic [15:0] lfsr_q, lfsr_n;
  mode_e mode_q, mode_n;
  // only the active pattern advances, so a mode change resumes the new pattern where it left off
  always_comb begin
    walk_n = adv && mode_q == MODE_WALK ? {walk_q[0], walk_q[DATA_WIDTH-1:1]} : walk_q;
    cnt_n  = adv && mode_q == MODE_CNT ? cnt_q + ONE : cnt_q;
    lfsr_n = adv && mode_q == MODE_PRBS ? lfsr_step(lfsr_q) : lfsr_q;
    mode_n = load ? mode_sel : mode_q;
  end
  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      walk_q <= ONE;
      cnt_q  <= '0;
      lfsr_q <= PRBS_SEED;
      mode_q <= MODE_WALK;
      data   <= ONE;
    end else begin
      walk_q <= walk_n;
      cnt_q  <= cnt_n;
      lfsr_q <= lfsr_n;
      mode_q <= mode_n;
      data   <= mode_n == MODE_CNT ? cnt_n : mode_n == MODE_PRBS ? {(DATA_WIDTH/16){lfsr_n}} : walk_n;
    end
  end
endmodule

// File: rtl/aurora_ll_pattern_gen.sv
// aurora_ll_pattern_gen: LocalLink TX frame generator with fixed/sweep length, gap control and traffic counters
module aurora_ll_pattern_gen
  import aurora_ll_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int REM_WIDTH  = 1,
  parameter int LEN_WIDTH  = 8,
  parameter int IFG_WIDTH  = 4
) (
  input  logic                 USER_CLK,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic [1:0]           MODE,
  input  logic                 FIXED_LEN,
  input  logic [LEN_WIDTH-1:0] LEN_CFG,
  input  logic [IFG_WIDTH-1:0] IFG_CFG,
  output logic [0:DATA_WIDTH-1] TX_D,
  output logic [REM_WIDTH-1:0] TX_REM,
  output logic                 TX_SOF_N,
  output logic                 TX_EOF_N,
  output logic                 TX_SRC_RDY_N,
  input  logic                 TX_DST_RDY_N,
  output logic [31:0]          FRAME_CNT,
  output logic [31:0]          WORD_CNT
);
  localparam logic [LEN_WIDTH:0] LEN_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH:0] LEN_MAX = {1'b1, {LEN_WIDTH{1'b0}}};
  localparam logic [IFG_WIDTH-1:0] IFG_ONE = {{(IFG_WIDTH-1){1'b0}}, 1'b1};
  state_e st_q, st_n;
  logic fixed_q, fixed_n, xfer, eof_x, ld, in_data_n, last_n;
  logic [LEN_WIDTH:0] len_q, len_n, sweep_q, sweep_n, idx_q, idx_n;
  logic [IFG_WIDTH-1:0] ifg_q, ifg_n, gap_q, gap_n;
  logic [31:0] frame_n;
  logic [DATA_WIDTH-1:0] pat_d;
  // ld marks every point where a new frame's configuration is sampled
  always_comb begin
    xfer      = st_q == ST_DATA && !TX_DST_RDY_N;
    eof_x     = xfer && idx_q == len_q;
    ld        = st_q == ST_IDLE || (st_q == ST_GAP && gap_q == IFG_ONE) || (eof_x && ifg_q == '0);
    sweep_n   = eof_x && !fixed_q ? (sweep_q == LEN_MAX ? LEN_ONE : sweep_q + LEN_ONE) : sweep_q;
    fixed_n   = ld ? FIXED_LEN : fixed_q;
    ifg_n     = ld ? IFG_CFG : ifg_q;
    len_n     = !ld ? len_q : FIXED_LEN ? {1'b0, LEN_CFG} + LEN_ONE : sweep_n;
    idx_n     = ld ? LEN_ONE : xfer ? idx_q + LEN_ONE : idx_q;
    gap_n     = eof_x ? ifg_q : st_q == ST_GAP ? gap_q - IFG_ONE : gap_q;
    st_n      = ld ? (ENABLE ? ST_DATA : ST_IDLE) : eof_x ? ST_GAP : st_q;
    frame_n   = FRAME_CNT + 32'(eof_x);
    in_data_n = st_n == ST_DATA;
    last_n    = in_data_n && idx_n == len_n;
  end
  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      st_q         <= ST_IDLE;
      fixed_q      <= 1'b1;
      len_q        <= LEN_ONE;
      sweep_q      <= LEN_ONE;
      idx_q        <= LEN_ONE;
      ifg_q        <= '0;
      gap_q        <= '0;
      FRAME_CNT    <= '0;
      WORD_CNT     <= '0;
      TX_SRC_RDY_N <= 1'b1;
      TX_SOF_N     <= 1'b1;
      TX_EOF_N     <= 1'b1;
      TX_REM       <= '1;
    end else begin
      st_q         <= st_n;
      fixed_q      <= fixed_n;
      len_q        <= len_n;
      sweep_q      <= sweep_n;
      idx_q        <= idx_n;
      ifg_q        <= ifg_n;
      gap_q        <= gap_n;
      FRAME_CNT    <= frame_n;
      WORD_CNT     <= WORD_CNT + 32'(xfer);
      TX_SRC_RDY_N <= !in_data_n;
      TX_SOF_N     <= !(in_data_n && idx_n == LEN_ONE);
      TX_EOF_N     <= !last_n;
      TX_REM       <= last_n && !fixed_n ? frame_n[REM_WIDTH-1:0] : '1;
    end
  end
  aurora_ll_pattern_src #(.DATA_WIDTH(DATA_WIDTH)) u_src (
    .USER_CLK(USER_CLK),
    .RESET(RESET),
    .adv(xfer),
    .load(ld),
    .mode_sel(norm_mode(MODE)),
    .data(pat_d)
  );
  assign TX_D = pat_d;
endmodule

// File: tb/tb_aurora_ll_pattern_gen.sv
// tb_aurora_ll_pattern_gen: random-traffic bench for 16- and 32-bit generators against a frame-level model
module tb_aurora_ll_pattern_gen;
  logic USER_CLK = 1'b0, RESET = 1'b1, ENABLE = 1'b0, FIXED_LEN = 1'b1, TX_DST_RDY_N = 1'b0;
  logic [1:0] MODE = 2'd0;
  logic [7:0] LEN_CFG = 8'd0;
  logic [3:0] IFG_CFG = 4'd0;
  logic [0:15] d0;
  logic [0:31] d1;
  logic [0:0] rem0;
  logic [1:0] rem1;
  logic sof0, eof0, src0, sof1, eof1, src1;
  logic [31:0] fc0, wc0, fc1, wc1;
  int tests = 0, fails = 0;
  bit bp = 1'b0;
  int m_pos[2], m_len[2], m_sweep[2], m_idle[2];
  bit m_act[2];
  int unsigned m_frames[2], m_words[2], m_wk[2];
  logic [63:0] m_ck[2];
  logic [15:0] m_lf[2];
  logic [15:0] t1_exp[4] = '{16'h0001, 16'h8000, 16'h4000, 16'h2000};

  always #5 USER_CLK = ~USER_CLK;

  aurora_ll_pattern_gen #(.DATA_WIDTH(16), .REM_WIDTH(1)) u16 (
    .USER_CLK(USER_CLK), .RESET(RESET), .ENABLE(ENABLE), .MODE(MODE), .FIXED_LEN(FIXED_LEN),
    .LEN_CFG(LEN_CFG), .IFG_CFG(IFG_CFG), .TX_D(d0), .TX_REM(rem0), .TX_SOF_N(sof0),
    .TX_EOF_N(eof0), .TX_SRC_RDY_N(src0), .TX_DST_RDY_N(TX_DST_RDY_N),
    .FRAME_CNT(fc0), .WORD_CNT(wc0));

  aurora_ll_pattern_gen #(.DATA_WIDTH(32), .REM_WIDTH(2)) u32 (
    .USER_CLK(USER_CLK), .RESET(RESET), .ENABLE(ENABLE), .MODE(MODE), .FIXED_LEN(FIXED_LEN),
    .LEN_CFG(LEN_CFG), .IFG_CFG(IFG_CFG), .TX_D(d1), .TX_REM(rem1), .TX_SOF_N(sof1),
    .TX_EOF_N(eof1), .TX_SRC_RDY_N(src1), .TX_DST_RDY_N(TX_DST_RDY_N),
    .FRAME_CNT(fc1), .WORD_CNT(wc1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_nx(input logic [15:0] s);
    logic [15:0] b;
    b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h1;
    return (s >> 1) | (b << 15);
  endfunction

  function automatic logic [63:0] exp_data(input int id);
    int dw;
    dw = id ? 32 : 16;
    if (MODE == 2'd1) return m_ck[id] & ((64'd1 << dw) - 64'd1);
    if (MODE == 2'd2) return id ? {32'd0, m_lf[id], m_lf[id]} : {48'd0, m_lf[id]};
    return 64'd1 << ((dw - int'(m_wk[id] % dw)) % dw);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 0; m_len[i] = 0; m_sweep[i] = 1; m_idle[i] = 1000; m_act[i] = 1'b0;
      m_frames[i] = 0; m_words[i] = 0; m_wk[i] = 0; m_ck[i] = 64'd0; m_lf[i] = 16'hACE1;
    end
  endtask

  task automatic mon(input int id, input logic [63:0] d, input logic [1:0] rem, input logic sof,
                     input logic eof, input logic src, input logic [31:0] fc, input logic [31:0] wc);
    logic [1:0] rmax;
    string p;
    rmax = id ? 2'b11 : 2'b01;
    p = id ? "w32" : "w16";
    chk({p, "_frame_cnt"}, fc, m_frames[id]);
    chk({p, "_word_cnt"}, wc, m_words[id]);
    if (m_act[id]) chk({p, "_src_mid_frame"}, src, 1'b0);
    else begin
      chk({p, "_start"}, !src, m_idle[id] >= int'(IFG_CFG) && ENABLE);
      if (src) m_idle[id]++;
      else begin
        m_act[id] = 1'b1;
        m_len[id] = FIXED_LEN ? int'(LEN_CFG) + 1 : m_sweep[id];
      end
    end
    if (!src) begin
      chk({p, "_data"}, d, exp_data(id));
      chk({p, "_sof"}, sof, m_pos[id] != 0);
      chk({p, "_eof"}, eof, m_pos[id] + 1 != m_len[id]);
      chk({p, "_rem"}, rem, (m_pos[id] + 1 == m_len[id] && !FIXED_LEN) ? (2'(m_frames[id]) & rmax) : rmax);
      if (!TX_DST_RDY_N) begin
        if (MODE == 2'd1) m_ck[id]++;
        else if (MODE == 2'd2) m_lf[id] = lfsr_nx(m_lf[id]);
        else m_wk[id]++;
        m_words[id]++;
        m_pos[id]++;
        if (m_pos[id] == m_len[id]) begin
          m_pos[id] = 0; m_act[id] = 1'b0; m_idle[id] = 0; m_frames[id]++;
          if (!FIXED_LEN) m_sweep[id] = m_sweep[id] == 256 ? 1 : m_sweep[id] + 1;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge USER_CLK);
    TX_DST_RDY_N = bp ? 1'($urandom_range(0, 1)) : 1'b0;
    mon(0, 64'(d0), {1'b0, rem0}, sof0, eof0, src0, fc0, wc0);
    mon(1, 64'(d1), rem1, sof1, eof1, src1, fc1, wc1);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(negedge USER_CLK);
    chk("rst_src", {src0, src1}, 2'b11);
    chk("rst_sof_eof", {sof0, eof0, sof1, eof1}, 4'hF);
    chk("rst_rem", {rem0, rem1}, 3'b111);
    chk("rst_cnt", {fc0, wc0, fc1, wc1}, 128'd0);
    chk("rst_d16", 64'(d0), 64'h1);
    chk("rst_d32", 64'(d1), 64'h1);
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    int i;
    ENABLE = 1'b0;
    i = 0;
    do begin step(); i++; end while ((m_act[0] || m_act[1]) && i < 600);
    chk("drain_done", m_act[0] || m_act[1], 1'b0);
    repeat (20) step();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge USER_CLK);
    do_reset();
    // fixed 4-word frames, walking one, gap of 2
    MODE = 2'd0; FIXED_LEN = 1'b1; LEN_CFG = 8'd3; IFG_CFG = 4'd2; bp = 1'b0; ENABLE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_src", src0, 1'b0);
      chk("t1_data", 64'(d0), 64'(t1_exp[k]));
      chk("t1_sof", sof0, k != 0);
      chk("t1_eof", eof0, k != 3);
    end
    step(); chk("t1_gap1", src0, 1'b1);
    step(); chk("t1_gap2", src0, 1'b1);
    step(); chk("t1_next_sof", {src0, sof0}, 2'b00);
    repeat (40) step();
    drain();
    // sweeping lengths back-to-back through the 256 -> 1 wrap
    do_reset();
    FIXED_LEN = 1'b0; IFG_CFG = 4'd0; MODE = 2'd0; ENABLE = 1'b1;
    step();
    chk("t2_len1", {src0, sof0, eof0}, 3'b000);
    for (int i = 0; i < 40000 && m_frames[0] < 258; i++) step();
    chk("t2_reached_wrap", m_frames[0] >= 258, 1'b1);
    drain();
    // counter pattern under random backpressure
    do_reset();
    MODE = 2'd1; FIXED_LEN = 1'b1; LEN_CFG = 8'($urandom_range(0, 15)); IFG_CFG = 4'($urandom_range(0, 3));
    bp = 1'b1; ENABLE = 1'b1;
    repeat (2000) step();
    drain();
    chk("t3_word_cnt", wc0, m_words[0]);
    // PRBS
    do_reset();
    MODE = 2'd2; FIXED_LEN = 1'b1; LEN_CFG = 8'd4; IFG_CFG = 4'd1; bp = 1'b0; ENABLE = 1'b1;
    step();
    chk("t4_first32", 64'(d1), 64'hACE1ACE1);
    bp = 1'b1;
    repeat (1500) step();
    drain();
    // random configuration segments without reset: patterns resume across mode changes
    for (int s = 0; s < 8; s++) begin
      MODE = 2'($urandom_range(0, 3)); FIXED_LEN = 1'($urandom_range(0, 1));
      LEN_CFG = 8'($urandom_range(0, 20)); IFG_CFG = 4'($urandom_range(0, 15));
      bp = 1'($urandom_range(0, 1)); ENABLE = 1'b1;
      repeat (400) step();
      drain();
    end
    // ENABLE drop mid-frame
    do_reset();
    MODE = 2'd1; FIXED_LEN = 1'b1; LEN_CFG = 8'd9; IFG_CFG = 4'd1; bp = 1'b0; ENABLE = 1'b1;
    for (int i = 0; i < 50 && m_pos[0] < 3; i++) step();
    ENABLE = 1'b0;
    repeat (30) step();
    chk("t5_frame_cnt", fc0, 32'd1);
    chk("t5_word_cnt", wc0, 32'd10);
    chk("t5_idle", src0, 1'b1);
    // RESET mid-frame
    do_reset();
    MODE = 2'd0; FIXED_LEN = 1'b1; LEN_CFG = 8'd9; IFG_CFG = 4'd0; bp = 1'b0; ENABLE = 1'b1;
    for (int i = 0; i < 50 && m_pos[0] < 5; i++) step();
    ENABLE = 1'b0;
    do_reset();
    ENABLE = 1'b1;
    step();
    chk("t6_restart_sof", {src0, sof0}, 2'b00);
    repeat (30) step();
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
